clk_enable_gen: RTL and testbench

Programmable enable sequencer that drives the `enable_i` input of `clock_divider`. On a start command it waits a configurable number of cycles, then holds its enable output high for a configured run length, or continuously. It can optionally repeat the delay/run pattern. It replaces ad-hoc enable counters in benches and top-levels with a reusable, registered, deterministic enable source.

---
 rtl/clk_en_pkg.sv | 5 +
 rtl/load_down_counter.sv | 21 ++
 rtl/clk_enable_gen.sv | 80 ++++++++
 tb/tb_clk_enable_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared state encoding and default counter width for clk_enable_gen
package clk_en_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter shared by the delay and run phases
module load_down_counter import clk_en_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_one_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : dec ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o    = cnt_q;
  assign is_one_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: delay/run enable sequencer with optional repeat, registered outputs
module clk_enable_gen import clk_en_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] run_len_i,
  input  logic             repeat_i,
  output logic             enable_o,
  output logic             busy_o,
  output logic             done_o
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] delay_q, run_len_q, cnt, load_val;
  logic repeat_q, load, dec, is_one, done_d, enable_q, busy_q, done_q;
  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt_o    (cnt),
    .is_one_o (is_one)
  );
  // A finite run always exits at 1, so a zero count in RUN means continuous mode.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = run_len_q;
    dec      = 1'b0;
    done_d   = 1'b0;
    if (stop_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (start_i) begin
        load     = 1'b1;
        state_d  = delay_i != '0 ? DELAY : RUN;
        load_val = delay_i != '0 ? delay_i : run_len_i;
      end
      DELAY: begin
        state_d = is_one ? RUN : DELAY;
        load    = is_one;
        dec     = !is_one;
      end
      RUN: if (is_one) begin
        done_d   = 1'b1;
        load     = repeat_q;
        state_d  = !repeat_q ? IDLE : delay_q != '0 ? DELAY : RUN;
        load_val = delay_q != '0 ? delay_q : run_len_q;
      end else dec = cnt != '0;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      run_len_q <= '0;
      repeat_q  <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= state_d == RUN;
      busy_q   <= state_d != IDLE;
      done_q   <= done_d;
      if (state_q == IDLE && start_i && !stop_i) begin
        delay_q   <= delay_i;
        run_len_q <= run_len_i;
        repeat_q  <= repeat_i;
      end else if (stop_i) repeat_q <= 1'b0;
    end
  end
  assign enable_o = enable_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed scenarios for clk_enable_gen with a gated toggle divider
module tb_clk_enable_gen;
  logic clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, repeat_i = 1'b0;
  logic [15:0] delay_i = '0, run_len_i = '0;
  logic enable_o, busy_o, done_o;
  logic div_q;
  int div_toggles = 0;
  int vectors = 0, miscompares = 0;
  always #5 clk_i = ~clk_i;
  clk_enable_gen #(.CNT_W(16)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .delay_i   (delay_i),
    .run_len_i (run_len_i),
    .repeat_i  (repeat_i),
    .enable_o  (enable_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );
  // Stand-in for clock_divider: toggles only on edges where enable_o is high
  always @(posedge clk_i) begin
    if (!rstn_i) div_q <= 1'b0;
    else if (enable_o) div_q <= ~div_q;
  end
  always @(div_q) div_toggles++;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic start(input int d, input int l, input logic r);
    delay_i   = 16'(d);
    run_len_i = 16'(l);
    repeat_i  = r;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask
  task automatic test_reset();
    rstn_i  = 1'b0;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d: got en/busy/done=%b want 000", k, {enable_o, busy_o, done_o});
      end
    end
    rstn_i  = 1'b1;
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_release k=%0d: got en/busy/done=%b want 000", k, {enable_o, busy_o, done_o});
      end
    end
  endtask
  task automatic test_single_run();
    logic [2:0] exp;
    start(4, 3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) tick();
      exp = {k >= 4 && k < 7, k < 7, k == 7};
      vectors++;
      if ({enable_o, busy_o, done_o} !== exp) begin
        miscompares++;
        $display("FAIL single_run k=%0d: got en/busy/done=%b want %b", k, {enable_o, busy_o, done_o}, exp);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] exp_tab [7] = '{3'b010, 3'b110, 3'b001, 3'b110, 3'b110, 3'b001, 3'b000};
    start(1, 1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k != 0) tick();
      if (k == 3) start_i = 1'b0;
      vectors++;
      if ({enable_o, busy_o, done_o} !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d: got en/busy/done=%b want %b", k, {enable_o, busy_o, done_o}, exp_tab[k]);
      end
      if (k == 2) begin
        delay_i   = 16'd0;
        run_len_i = 16'd2;
        start_i   = 1'b1;
      end
    end
  endtask
  task automatic test_continuous();
    int c0;
    start(0, 0, 1'b0);
    c0 = div_toggles;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) tick();
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b110) begin
        miscompares++;
        $display("FAIL continuous k=%0d: got en/busy/done=%b want 110", k, {enable_o, busy_o, done_o});
      end
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    vectors++;
    if ({enable_o, busy_o, done_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL continuous_stop: got en/busy/done=%b want 000", {enable_o, busy_o, done_o});
    end
    vectors++;
    if (div_toggles - c0 !== 20) begin
      miscompares++;
      $display("FAIL divider_enabled: got %0d toggles want 20", div_toggles - c0);
    end
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (div_toggles - c0 !== 20) begin
      miscompares++;
      $display("FAIL divider_disabled: got %0d toggles want 20", div_toggles - c0);
    end
  endtask
  task automatic test_repeat();
    logic [2:0] exp;
    start(2, 2, 1'b1);
    repeat_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) tick();
      exp = {k % 4 >= 2, 1'b1, k > 0 && k % 4 == 0};
      vectors++;
      if ({enable_o, busy_o, done_o} !== exp) begin
        miscompares++;
        $display("FAIL repeat k=%0d: got en/busy/done=%b want %b", k, {enable_o, busy_o, done_o}, exp);
      end
    end
    stop_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      stop_i = 1'b0;
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL repeat_stop k=%0d: got en/busy/done=%b want 000", k, {enable_o, busy_o, done_o});
      end
    end
  endtask
  task automatic test_ignored_inputs();
    logic [2:0] exp;
    start(3, 5, 1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k != 0) tick();
      if (k == 5) start_i = 1'b0;
      exp = {k >= 3 && k < 8, k < 8, k == 8};
      vectors++;
      if ({enable_o, busy_o, done_o} !== exp) begin
        miscompares++;
        $display("FAIL ignored k=%0d: got en/busy/done=%b want %b", k, {enable_o, busy_o, done_o}, exp);
      end
      if (k == 4) begin
        start_i   = 1'b1;
        delay_i   = 16'd1;
        run_len_i = 16'd1;
        repeat_i  = 1'b1;
      end
    end
    delay_i   = 16'd0;
    run_len_i = 16'd0;
    repeat_i  = 1'b0;
    start_i   = 1'b1;
    stop_i    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      start_i = 1'b0;
      stop_i  = 1'b0;
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL start_stop_idle k=%0d: got en/busy/done=%b want 000", k, {enable_o, busy_o, done_o});
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [2:0] exp_tab [5] = '{3'b010, 3'b110, 3'b110, 3'b001, 3'b000};
    start(1, 10, 1'b0);
    tick();
    tick();
    vectors++;
    if ({enable_o, busy_o, done_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL pre_reset_run: got en/busy/done=%b want 110", {enable_o, busy_o, done_o});
    end
    rstn_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      rstn_i = 1'b1;
      vectors++;
      if ({enable_o, busy_o, done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d: got en/busy/done=%b want 000", k, {enable_o, busy_o, done_o});
      end
    end
    start(1, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) tick();
      vectors++;
      if ({enable_o, busy_o, done_o} !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL fresh_start k=%0d: got en/busy/done=%b want %b", k, {enable_o, busy_o, done_o}, exp_tab[k]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_continuous();
    test_repeat();
    test_ignored_inputs();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
